pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Consumer of the hazard unit's stall vector. Turns stall_n, branch-resolve, memory-busy and halt
//  requests into the per-stage write-enable and flush strobes of the 5-stage pipelined MIPS core.
//  Sits beside the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) and owns halt draining
//  and stall/flush performance counters.
// PARAMETERS
//  DRAIN_CYCLES  4   cycles spent draining EX/MEM/WB after a halt is accepted (>=1)
//  CNT_W         16  width of each saturating performance counter
// PORTS
//  clk              in   1      core clock, all state on rising edge
//  rst              in   1      asynchronous, active-high reset
//  stall_n          in   3      hazard vector; 3'b111 = no hazard, any 0 bit = load-use hazard
//  branch_taken_EX  in   1      branch/jump in EX redirects PC this cycle
//  mem_busy         in   1      data memory not ready; whole pipeline must freeze
//  halt_req         in   1      halt instruction decoded in ID
//  clr_counters     in   1      synchronous clear of both counters
//  pc_write_en      out  1      PC register load enable
//  IF_ID_write_en   out  1      IF/ID register load enable
//  IF_ID_flush      out  1      load bubble into IF/ID
//  ID_EX_flush      out  1      load bubble (zeroed controls) into ID/EX
//  EX_MEM_write_en  out  1      EX/MEM load enable
//  MEM_WB_write_en  out  1      MEM/WB load enable
//  halted           out  1      core halted, pipeline empty
//  stall_cycles     out  CNT_W  cycles lost to load-use stalls plus mem_busy freezes
//  flush_events     out  CNT_W  number of taken-branch flushes
// BEHAVIOUR
//  - States: IDLE, RUN, DRAIN, HALTED. Outputs are combinational from state + inputs (Mealy).
//  - Reset (async): state=IDLE, lu_hold=0, drain_cnt=0, counters=0. IDLE: all *_write_en=0,
//    both flushes=1, halted=0. IDLE->RUN on first rising edge with rst low.
//  - RUN, priority order (first match wins):
//    1 mem_busy: all write enables 0, flushes 0; lu_hold held; stall_cycles++.
//    2 branch_taken_EX: all write enables 1, IF_ID_flush=1, ID_EX_flush=1; flush_events++;
//      lu_hold<=0; coincident load-use or halt_req ignored (squashed younger instrs).
//    3 stall_n!=3'b111 and !lu_hold: pc_write_en=0, IF_ID_write_en=0, ID_EX_flush=1, rest 1;
//      stall_cycles++; lu_hold<=1. Stall lasts exactly one non-frozen cycle.
//    4 halt_req: pc_write_en=0, IF_ID_flush=1, others enabled; drain_cnt<=DRAIN_CYCLES-1;
//      ->DRAIN.
//    5 otherwise: all write enables 1, flushes 0; lu_hold<=0.
//    stall_n!=3'b111 while lu_hold=1 is treated as case 5 (hazard re-seen on bubble).
//  - DRAIN: pc_write_en=0, IF_ID_write_en=1, IF_ID_flush=1, ID_EX_flush=1, EX_MEM/MEM_WB=1.
//    mem_busy: all enables 0, drain_cnt held, stall_cycles++. branch_taken_EX (older branch):
//    apply case 2, ->RUN, halt cancelled. Else drain_cnt==0 ->HALTED, otherwise decrement.
//  - HALTED: all write enables 0, flushes 0, halted=1; exits only via rst.
//  - Counters saturate at all-ones; clr_counters wins over same-cycle increment.
// STRUCTURE
//  - Package pipeline_ctrl_pkg: state encodings, STALL_NONE=3'b111.
//  - Sub-module sat_counter #(CNT_W) (inc, clr, q), instantiated for both counters.
// TESTING
//  - Reset: rst=1 async mid-cycle -> IDLE outputs at once; release -> RUN next edge, all enables 1.
//  - Load-use: stall_n=3'b000 for 2 cycles -> pc/IF_ID enable 0 + ID_EX_flush for cycle 1 only;
//    cycle 2 runs; stall_cycles=1.
//  - Branch vs load-use: branch_taken_EX=1 with stall_n=3'b000 -> both flushes 1, pc_write_en=1,
//    flush_events=1, stall_cycles=0.
//  - Freeze: mem_busy=1 for 3 cycles during load-use stall -> all enables 0, stall completes
//    after release, stall_cycles=4.
//  - Halt: halt_req=1 -> halted=1 exactly DRAIN_CYCLES+1 edges later (5 with default);
//    branch_taken_EX in DRAIN cycle 2 -> back to RUN, halted stays 0.
//  - Saturation: CNT_W=4, 20 stall cycles -> stall_cycles=15; clr_counters with inc -> 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared state encoding and hazard-vector constant for the pipeline controller.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_e;
  localparam logic [2:0] STALL_NONE = 3'b111;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/request inputs and per-stage enable/flush strobes of the pipeline controller.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
  logic [2:0] stall_n;
  logic branch_taken_EX, mem_busy, halt_req, clr_counters;
  logic pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, MEM_WB_write_en, halted;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output stall_n, branch_taken_EX, mem_busy, halt_req, clr_counters,
    input pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, MEM_WB_write_en,
    input halted, stall_cycles, flush_events
  );
  modport slave (
    input stall_n, branch_taken_EX, mem_busy, halt_req, clr_counters,
    output pc_write_en, IF_ID_write_en, IF_ID_flush, ID_EX_flush, EX_MEM_write_en, MEM_WB_write_en,
    output halted, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// sat_counter: saturating up-counter whose synchronous clear beats a same-cycle increment.
module sat_counter #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = clr ? '0 : (inc && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign q = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: turns hazard, branch, memory-busy and halt requests into per-stage enables/flushes.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  state_e state_d, state_q;
  logic lu_hold_d, lu_hold_q, stall_inc, flush_inc, hazard;
  logic [DW-1:0] drain_d, drain_q;
  assign hazard = bus.stall_n != STALL_NONE;
  always_comb begin
    state_d = state_q;
    lu_hold_d = lu_hold_q;
    drain_d = drain_q;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    bus.pc_write_en = 1'b0;
    bus.IF_ID_write_en = 1'b0;
    bus.IF_ID_flush = 1'b0;
    bus.ID_EX_flush = 1'b0;
    bus.EX_MEM_write_en = 1'b0;
    bus.MEM_WB_write_en = 1'b0;
    bus.halted = state_q == HALTED;
    if (state_q == IDLE) begin
      bus.IF_ID_flush = 1'b1;
      bus.ID_EX_flush = 1'b1;
      state_d = RUN;
    end else if (state_q != HALTED) begin
      if (bus.mem_busy) begin
        stall_inc = 1'b1;
      end else if (bus.branch_taken_EX) begin
        // an older branch also cancels a halt that is still draining
        {bus.pc_write_en, bus.IF_ID_write_en, bus.IF_ID_flush, bus.ID_EX_flush} = 4'b1111;
        {bus.EX_MEM_write_en, bus.MEM_WB_write_en} = 2'b11;
        flush_inc = 1'b1;
        lu_hold_d = 1'b0;
        state_d = RUN;
      end else if (state_q == DRAIN) begin
        {bus.IF_ID_write_en, bus.IF_ID_flush, bus.ID_EX_flush} = 3'b111;
        {bus.EX_MEM_write_en, bus.MEM_WB_write_en} = 2'b11;
        state_d = drain_q == '0 ? HALTED : DRAIN;
        drain_d = drain_q == '0 ? drain_q : drain_q - DW'(1);
      end else if (hazard && !lu_hold_q) begin
        {bus.ID_EX_flush, bus.EX_MEM_write_en, bus.MEM_WB_write_en} = 3'b111;
        stall_inc = 1'b1;
        lu_hold_d = 1'b1;
      end else if (bus.halt_req) begin
        {bus.IF_ID_write_en, bus.IF_ID_flush} = 2'b11;
        {bus.EX_MEM_write_en, bus.MEM_WB_write_en} = 2'b11;
        drain_d = DW'(DRAIN_CYCLES - 1);
        state_d = DRAIN;
      end else begin
        {bus.pc_write_en, bus.IF_ID_write_en} = 2'b11;
        {bus.EX_MEM_write_en, bus.MEM_WB_write_en} = 2'b11;
        lu_hold_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      lu_hold_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      lu_hold_q <= lu_hold_d;
      drain_q <= drain_d;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(stall_inc), .clr(bus.clr_counters), .q(bus.stall_cycles)
  );
  sat_counter #(.CNT_W(CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(flush_inc), .clr(bus.clr_counters), .q(bus.flush_events)
  );
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed and random checks of pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;
  localparam int DRAIN = 4;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_HALT = 3;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int m_phase, m_left, m_stall, m_flush;
  bit m_bubble;
  pipeline_ctrl_if #(.CNT_W(16)) bus ();
  pipeline_ctrl_if #(.CNT_W(4)) bus4 ();
  assign bus4.stall_n = bus.stall_n;
  assign bus4.branch_taken_EX = bus.branch_taken_EX;
  assign bus4.mem_busy = bus.mem_busy;
  assign bus4.halt_req = bus.halt_req;
  assign bus4.clr_counters = bus.clr_counters;
  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  pipeline_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  always #5 clk = ~clk;
  function automatic int sat(input int v, input int w);
    return v > (1 << w) - 1 ? (1 << w) - 1 : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] outs();
    return {bus.pc_write_en, bus.IF_ID_write_en, bus.IF_ID_flush, bus.ID_EX_flush,
            bus.EX_MEM_write_en, bus.MEM_WB_write_en, bus.halted};
  endfunction
  task automatic check_counters();
    chk("stall16", 32'(bus.stall_cycles), sat(m_stall, 16));
    chk("flush16", 32'(bus.flush_events), sat(m_flush, 16));
    chk("stall4", 32'(bus4.stall_cycles), sat(m_stall, 4));
    chk("flush4", 32'(bus4.flush_events), sat(m_flush, 4));
  endtask
  // expected strobes {pc, if_id_we, if_id_fl, id_ex_fl, ex_mem, mem_wb, halted}; advances the model
  task automatic model(input logic [2:0] sn, input logic br, mb, hr, cl, output logic [6:0] exp);
    bit si = 0, fi = 0;
    exp = '0;
    if (m_phase == PH_IDLE) begin exp = 7'b0011000; m_phase = PH_RUN; end
    else if (m_phase == PH_HALT) exp = 7'b0000001;
    else if (mb) si = 1;
    else if (br) begin exp = 7'b1111110; fi = 1; m_bubble = 0; m_phase = PH_RUN; end
    else if (m_phase == PH_DRAIN) begin
      exp = 7'b0111110;
      m_left--;
      if (m_left == 0) m_phase = PH_HALT;
    end
    else if (sn != 3'b111 && !m_bubble) begin exp = 7'b0001110; si = 1; m_bubble = 1; end
    else if (hr) begin exp = 7'b0110110; m_left = DRAIN; m_phase = PH_DRAIN; end
    else begin exp = 7'b1100110; m_bubble = 0; end
    if (cl) begin m_stall = 0; m_flush = 0; end
    else begin m_stall += int'(si); m_flush += int'(fi); end
  endtask
  task automatic step(input logic [2:0] sn, input logic br, mb, hr, cl);
    logic [6:0] exp;
    bus.stall_n = sn;
    bus.branch_taken_EX = br;
    bus.mem_busy = mb;
    bus.halt_req = hr;
    bus.clr_counters = cl;
    #3;
    model(sn, br, mb, hr, cl, exp);
    chk("strobes", 32'(outs()), 32'(exp));
    @(posedge clk); #1;
    check_counters();
  endtask
  // called at posedge+1: async assert mid-cycle, release before the next edge, end in RUN
  task automatic do_reset();
    bus.stall_n = 3'b111;
    {bus.branch_taken_EX, bus.mem_busy, bus.halt_req, bus.clr_counters} = '0;
    #2 rst = 1'b1;
    #1;
    m_phase = PH_IDLE; m_bubble = 0; m_left = 0; m_stall = 0; m_flush = 0;
    chk("rst_async", 32'(outs()), 32'(7'b0011000));
    check_counters();
    @(negedge clk) rst = 1'b0;
    #1 chk("idle_out", 32'(outs()), 32'(7'b0011000));
    m_phase = PH_RUN;
    @(posedge clk); #1;
  endtask
  initial begin
    bus.stall_n = 3'b111;
    {bus.branch_taken_EX, bus.mem_busy, bus.halt_req, bus.clr_counters} = '0;
    @(posedge clk); #1;
    do_reset();
    step(3'b111, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0);
    chk("lu_stall_cnt", 32'(bus.stall_cycles), 1);
    do_reset();
    step(3'b000, 1, 0, 0, 0);
    chk("br_flush_cnt", 32'(bus.flush_events), 1);
    chk("br_stall_cnt", 32'(bus.stall_cycles), 0);
    do_reset();
    repeat (3) step(3'b000, 0, 1, 0, 0);
    step(3'b000, 0, 0, 0, 0);
    step(3'b000, 0, 0, 0, 0);
    chk("freeze_cnt", 32'(bus.stall_cycles), 4);
    do_reset();
    step(3'b111, 0, 0, 1, 0);
    repeat (DRAIN - 1) step(3'b111, 0, 0, 0, 0);
    chk("halt_early", 32'(bus.halted), 0);
    step(3'b111, 0, 0, 0, 0);
    chk("halt_edge", 32'(bus.halted), 1);
    step(3'b111, 1, 0, 0, 0);
    chk("halt_sticky", 32'(bus.halted), 1);
    do_reset();
    step(3'b111, 0, 0, 1, 0);
    step(3'b111, 0, 0, 0, 0);
    step(3'b111, 1, 0, 0, 0);
    repeat (DRAIN + 2) step(3'b111, 0, 0, 0, 0);
    chk("halt_cancel", 32'(bus.halted), 0);
    do_reset();
    repeat (20) step(3'b111, 0, 1, 0, 0);
    chk("sat4", 32'(bus4.stall_cycles), 15);
    chk("nosat16", 32'(bus.stall_cycles), 20);
    step(3'b111, 0, 1, 0, 1);
    chk("clr_wins", 32'(bus4.stall_cycles), 0);
    for (int i = 0; i < 800; i++) begin
      if (i % 160 == 0) do_reset();
      step(($urandom % 3 == 0) ? 3'($urandom) : 3'b111, $urandom % 8 == 0, $urandom % 6 == 0,
           $urandom % 25 == 0, $urandom % 60 == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
